// File: rtl/femto_bus_pkg.sv
// Shared definitions for the core bus: master indices, arbitration modes, request bundle.
// Types and constants only.
package femto_bus_pkg;

    localparam logic M_IBUS = 1'b0;
    localparam logic M_DBUS = 1'b1;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    typedef struct packed {
        logic [31:0] addr;
        logic        prot;
        logic [1:0]  size;
        logic        write;
        logic        trans;
    } bus_req_t;

endpackage

// File: rtl/busarb_rspbuf.sv
// Per-master response holding register: keeps a finished data phase for a master whose next address lost arbitration.
// Zero latency when empty (slave response passes through); holds until the master sees ready.
module busarb_rspbuf
    import femto_bus_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        cap,
    input  logic        clr,
    input  logic [31:0] slv_rdata,
    input  logic        slv_resp,
    output logic [31:0] rdata,
    output logic        resp,
    output logic        vld
);

    logic [31:0] rb_dat;
    logic        rb_err;

    // Capture only happens while the master is stalled, so it never overlaps a clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld    <= 1'b0;
            rb_dat <= 32'h0;
            rb_err <= 1'b0;
        end else if (cap) begin
            vld    <= 1'b1;
            rb_dat <= slv_rdata;
            rb_err <= slv_resp;
        end else if (clr) begin
            vld    <= 1'b0;
        end
    end

    assign rdata = vld ? rb_dat    : slv_rdata;
    assign resp  = vld ? rb_err    : slv_resp;

endmodule

// File: rtl/busarb.sv
// Two-master (ibus/dbus) to one-slave arbiter; combinational address path, zero added latency uncontested.
// A losing master sees hready low; its completed read is parked in a response buffer until it is regranted.
module busarb
    import femto_bus_pkg::*;
#(
    parameter int ARB_MODE = ARB_FIXED,
    parameter int RST_LAST = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] m0_haddr,
    input  logic        m0_hprot,
    input  logic [1:0]  m0_hsize,
    input  logic        m0_hwrite,
    input  logic [31:0] m0_hwdata,
    input  logic        m0_htrans,
    output logic [31:0] m0_hrdata,
    output logic        m0_hresp,
    output logic        m0_hready,
    input  logic [31:0] m1_haddr,
    input  logic        m1_hprot,
    input  logic [1:0]  m1_hsize,
    input  logic        m1_hwrite,
    input  logic [31:0] m1_hwdata,
    input  logic        m1_htrans,
    output logic [31:0] m1_hrdata,
    output logic        m1_hresp,
    output logic        m1_hready,
    output logic [31:0] haddr,
    output logic        hprot,
    output logic [1:0]  hsize,
    output logic        hwrite,
    output logic [31:0] hwdata,
    output logic        htrans,
    input  logic [31:0] hrdata,
    input  logic        hresp,
    input  logic        hready
);

    localparam logic RST_G = (RST_LAST != 0);

    bus_req_t req0, req1, sel;
    logic     hold_vld, hold_g;
    logic     dp_vld, dp_own;
    logic     last_g, g;
    logic     rdy0, rdy1, cap0, cap1, rb_vld0, rb_vld1;

    assign req0 = {m0_haddr, m0_hprot, m0_hsize, m0_hwrite, m0_htrans};
    assign req1 = {m1_haddr, m1_hprot, m1_hsize, m1_hwrite, m1_htrans};

    // A stalled address phase keeps its grant; otherwise arbitrate fresh.
    always_comb begin
        g = last_g;
        if (hold_vld)
            g = hold_g;
        else if (m0_htrans && m1_htrans)
            g = (ARB_MODE == ARB_FIXED) ? M_DBUS : ~last_g;
        else if (m1_htrans)
            g = M_DBUS;
        else if (m0_htrans)
            g = M_IBUS;
    end

    assign sel    = g ? req1 : req0;
    assign haddr  = sel.addr;
    assign hprot  = sel.prot;
    assign hsize  = sel.size;
    assign hwrite = sel.write;
    assign htrans = sel.trans;
    assign hwdata = !dp_vld ? 32'h0 : (dp_own ? m1_hwdata : m0_hwdata);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_vld <= 1'b0;
            hold_g   <= 1'b0;
            dp_vld   <= 1'b0;
            dp_own   <= 1'b0;
            last_g   <= RST_G;
        end else begin
            hold_vld <= htrans & ~hready;
            hold_g   <= g;
            if (hready) begin
                dp_vld <= htrans;
                dp_own <= g;
                if (htrans)
                    last_g <= g;
            end
        end
    end

    // Ready needs both this master's data phase finished and its new address (if any) taken.
    assign rdy0 = (rb_vld0 | ~(dp_vld & (dp_own == M_IBUS)) | hready)
                & (~m0_htrans | ((g == M_IBUS) & hready));
    assign rdy1 = (rb_vld1 | ~(dp_vld & (dp_own == M_DBUS)) | hready)
                & (~m1_htrans | ((g == M_DBUS) & hready));

    assign cap0 = dp_vld & (dp_own == M_IBUS) & hready & ~rdy0;
    assign cap1 = dp_vld & (dp_own == M_DBUS) & hready & ~rdy1;

    assign m0_hready = rdy0;
    assign m1_hready = rdy1;

    busarb_rspbuf u_rb0 (
        .clk       (clk),
        .rstn      (rstn),
        .cap       (cap0),
        .clr       (rdy0),
        .slv_rdata (hrdata),
        .slv_resp  (hresp),
        .rdata     (m0_hrdata),
        .resp      (m0_hresp),
        .vld       (rb_vld0)
    );

    busarb_rspbuf u_rb1 (
        .clk       (clk),
        .rstn      (rstn),
        .cap       (cap1),
        .clr       (rdy1),
        .slv_rdata (hrdata),
        .slv_resp  (hresp),
        .rdata     (m1_hrdata),
        .resp      (m1_hresp),
        .vld       (rb_vld1)
    );

endmodule

// File: tb/tb_busarb.sv
// Bench for busarb: round-robin and fixed-priority instances share stimulus and are checked
// every cycle against a behavioural model, plus directed literal checks.
module tb_busarb;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [31:0] m_addr [2];
    logic        m_prot [2];
    logic [1:0]  m_size [2];
    logic        m_write[2];
    logic [31:0] m_wdata[2];
    logic        m_trans[2];
    logic [31:0] s_rdata;
    logic        s_resp, s_ready;

    logic [31:0] r_haddr, r_hwdata, r_m0_hrdata, r_m1_hrdata;
    logic        r_hprot, r_hwrite, r_htrans, r_m0_hresp, r_m0_hready, r_m1_hresp, r_m1_hready;
    logic [1:0]  r_hsize;
    logic [31:0] f_haddr, f_hwdata, f_m0_hrdata, f_m1_hrdata;
    logic        f_hprot, f_hwrite, f_htrans, f_m0_hresp, f_m0_hready, f_m1_hresp, f_m1_hready;
    logic [1:0]  f_hsize;

    busarb #(.ARB_MODE(0), .RST_LAST(1)) u_rr (
        .clk(clk), .rstn(rstn),
        .m0_haddr(m_addr[0]), .m0_hprot(m_prot[0]), .m0_hsize(m_size[0]), .m0_hwrite(m_write[0]),
        .m0_hwdata(m_wdata[0]), .m0_htrans(m_trans[0]),
        .m0_hrdata(r_m0_hrdata), .m0_hresp(r_m0_hresp), .m0_hready(r_m0_hready),
        .m1_haddr(m_addr[1]), .m1_hprot(m_prot[1]), .m1_hsize(m_size[1]), .m1_hwrite(m_write[1]),
        .m1_hwdata(m_wdata[1]), .m1_htrans(m_trans[1]),
        .m1_hrdata(r_m1_hrdata), .m1_hresp(r_m1_hresp), .m1_hready(r_m1_hready),
        .haddr(r_haddr), .hprot(r_hprot), .hsize(r_hsize), .hwrite(r_hwrite),
        .hwdata(r_hwdata), .htrans(r_htrans),
        .hrdata(s_rdata), .hresp(s_resp), .hready(s_ready)
    );

    busarb #(.ARB_MODE(1), .RST_LAST(0)) u_fx (
        .clk(clk), .rstn(rstn),
        .m0_haddr(m_addr[0]), .m0_hprot(m_prot[0]), .m0_hsize(m_size[0]), .m0_hwrite(m_write[0]),
        .m0_hwdata(m_wdata[0]), .m0_htrans(m_trans[0]),
        .m0_hrdata(f_m0_hrdata), .m0_hresp(f_m0_hresp), .m0_hready(f_m0_hready),
        .m1_haddr(m_addr[1]), .m1_hprot(m_prot[1]), .m1_hsize(m_size[1]), .m1_hwrite(m_write[1]),
        .m1_hwdata(m_wdata[1]), .m1_htrans(m_trans[1]),
        .m1_hrdata(f_m1_hrdata), .m1_hresp(f_m1_hresp), .m1_hready(f_m1_hready),
        .haddr(f_haddr), .hprot(f_hprot), .hsize(f_hsize), .hwrite(f_hwrite),
        .hwdata(f_hwdata), .htrans(f_htrans),
        .hrdata(s_rdata), .hresp(s_resp), .hready(s_ready)
    );

    logic [136:0] dv_rr, dv_fx;
    assign dv_rr = {r_haddr, r_hprot, r_hsize, r_hwrite, r_hwdata, r_htrans,
                    r_m0_hrdata, r_m0_hresp, r_m0_hready, r_m1_hrdata, r_m1_hresp, r_m1_hready};
    assign dv_fx = {f_haddr, f_hprot, f_hsize, f_hwrite, f_hwdata, f_htrans,
                    f_m0_hrdata, f_m0_hresp, f_m0_hready, f_m1_hrdata, f_m1_hresp, f_m1_hready};

    // Model state, index k: 0 = round-robin instance, 1 = fixed-priority instance.
    bit          stalled[2], stalled_who[2], busy[2], busy_who[2], prev[2];
    bit          saved  [2][2];
    logic [31:0] saved_d[2][2];
    bit          saved_e[2][2];
    int          e_who  [2];
    bit          e_trans[2];
    bit          e_rdy  [2][2];
    logic [136:0] evec  [2];

    int checks = 0;
    int errors = 0;

    task automatic model_reset(input int k);
        stalled[k] = 0; stalled_who[k] = 0; busy[k] = 0; busy_who[k] = 0;
        prev[k] = (k == 0) ? 1'b1 : 1'b0;
        for (int i = 0; i < 2; i++) saved[k][i] = 0;
    endtask

    task automatic model_eval(input int k);
        int nreq, who;
        logic [31:0] wd;
        logic [31:0] rd[2];
        bit rs[2];
        nreq = int'(m_trans[0]) + int'(m_trans[1]);
        if (stalled[k])   who = int'(stalled_who[k]);
        else if (nreq == 2) who = (k == 1) ? 1 : 1 - int'(prev[k]);
        else if (nreq == 1) who = m_trans[1] ? 1 : 0;
        else                who = int'(prev[k]);
        e_who[k]   = who;
        e_trans[k] = m_trans[who];
        wd = busy[k] ? m_wdata[int'(busy_who[k])] : 32'h0;
        for (int i = 0; i < 2; i++) begin
            bit finished, accepted;
            finished = saved[k][i] || !(busy[k] && int'(busy_who[k]) == i) || s_ready;
            accepted = !m_trans[i] || (who == i && s_ready);
            e_rdy[k][i] = finished && accepted;
            rd[i] = saved[k][i] ? saved_d[k][i] : s_rdata;
            rs[i] = saved[k][i] ? saved_e[k][i] : s_resp;
        end
        evec[k] = {m_addr[who], m_prot[who], m_size[who], m_write[who], wd, m_trans[who],
                   rd[0], rs[0], e_rdy[k][0], rd[1], rs[1], e_rdy[k][1]};
    endtask

    task automatic model_step(input int k);
        for (int i = 0; i < 2; i++) begin
            if (busy[k] && int'(busy_who[k]) == i && s_ready && !e_rdy[k][i]) begin
                saved[k][i] = 1; saved_d[k][i] = s_rdata; saved_e[k][i] = s_resp;
            end else if (e_rdy[k][i]) begin
                saved[k][i] = 0;
            end
        end
        stalled[k]     = e_trans[k] && !s_ready;
        stalled_who[k] = (e_who[k] == 1);
        if (s_ready) begin
            busy[k]     = e_trans[k];
            busy_who[k] = (e_who[k] == 1);
            if (e_trans[k]) prev[k] = (e_who[k] == 1);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rstn) model_reset(k);
            model_eval(k);
        end
        checks++;
        if (dv_rr !== evec[0]) begin
            errors++;
            $display("FAIL rr_cycle t=%0t got %h expected %h", $time, dv_rr, evec[0]);
        end
        checks++;
        if (dv_fx !== evec[1]) begin
            errors++;
            $display("FAIL fx_cycle t=%0t got %h expected %h", $time, dv_fx, evec[1]);
        end
    end

    always @(posedge clk) begin
        if (rstn)
            for (int k = 0; k < 2; k++) model_step(k);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic setm(input int i, input bit tr, input logic [31:0] a, input bit wr, input logic [31:0] wd);
        m_trans[i] = tr; m_addr[i] = a; m_write[i] = wr; m_wdata[i] = wd;
    endtask

    task automatic idle_all();
        m_trans[0] = 0; m_trans[1] = 0;
    endtask

    initial begin
        rstn = 0; s_rdata = 32'h55AA; s_resp = 0; s_ready = 1;
        for (int i = 0; i < 2; i++) begin
            m_addr[i] = 0; m_prot[i] = 0; m_size[i] = 2'd2; m_write[i] = 0; m_wdata[i] = 0; m_trans[i] = 0;
        end
        sample();
        chk("rst_htrans_rr", 32'(r_htrans), 0);
        chk("rst_htrans_fx", 32'(f_htrans), 0);
        chk("rst_m0_rdy", 32'(r_m0_hready), 1);
        chk("rst_m1_rdy", 32'(r_m1_hready), 1);
        chk("rst_m0_rdata", r_m0_hrdata, 32'h55AA);

        cyc(); rstn = 1; idle_all();
        // single master back-to-back
        cyc(); setm(0, 1, 32'h100, 0, 0);
        sample(); chk("sm_addr0", r_haddr, 32'h100); chk("sm_rdy0", 32'(r_m0_hready), 1);
        cyc(); setm(0, 1, 32'h104, 0, 0); s_rdata = 32'h11;
        sample(); chk("sm_addr1", r_haddr, 32'h104); chk("sm_rdy1", 32'(r_m0_hready), 1);
        chk("sm_data0", r_m0_hrdata, 32'h11);
        cyc(); idle_all(); s_rdata = 32'h22;
        sample(); chk("sm_data1", r_m0_hrdata, 32'h22); chk("sm_rdy2", 32'(r_m0_hready), 1);

        // simultaneous request, fixed priority
        cyc(); setm(0, 1, 32'h200, 0, 0); setm(1, 1, 32'h8000_0000, 1, 32'hDEADBEEF);
        sample(); chk("col_addr", f_haddr, 32'h8000_0000); chk("col_m0_rdy", 32'(f_m0_hready), 0);
        chk("col_m1_rdy", 32'(f_m1_hready), 1);
        cyc(); m_trans[1] = 0;
        sample(); chk("col_addr_m0", f_haddr, 32'h200); chk("col_m0_acc", 32'(f_m0_hready), 1);
        chk("col_wdata", f_hwdata, 32'hDEADBEEF);
        cyc(); idle_all(); s_rdata = 32'h33;
        sample(); chk("col_m0_data", f_m0_hrdata, 32'h33);

        // response buffering, round-robin
        cyc(); setm(0, 1, 32'h300, 0, 0);
        cyc(); setm(0, 1, 32'h304, 0, 0); setm(1, 1, 32'h400, 0, 0); s_rdata = 32'h13;
        sample(); chk("rb_addr", r_haddr, 32'h400); chk("rb_m0_stall", 32'(r_m0_hready), 0);
        cyc(); m_trans[1] = 0; s_rdata = 32'h44;
        sample(); chk("rb_m0_rdy", 32'(r_m0_hready), 1); chk("rb_m0_data", r_m0_hrdata, 32'h13);
        chk("rb_m1_data", r_m1_hrdata, 32'h44); chk("rb_addr2", r_haddr, 32'h304);
        cyc(); idle_all(); s_rdata = 32'h55;
        sample(); chk("rb_m0_next", r_m0_hrdata, 32'h55);

        // slave stall during m1 address phase
        cyc(); setm(1, 1, 32'h500, 0, 0); s_ready = 0;
        sample(); chk("st_addr0", r_haddr, 32'h500);
        cyc(); setm(0, 1, 32'h600, 0, 0);
        sample(); chk("st_addr1", r_haddr, 32'h500); chk("st_m0_rdy", 32'(r_m0_hready), 0);
        chk("st_addr1_fx", f_haddr, 32'h500);
        cyc();
        sample(); chk("st_addr2", r_haddr, 32'h500);
        cyc(); s_ready = 1;
        sample(); chk("st_addr3", r_haddr, 32'h500); chk("st_trans3", 32'(r_htrans), 1);
        cyc(); m_trans[1] = 0;
        sample(); chk("st_after", r_haddr, 32'h600);
        cyc(); idle_all();

        // error on m1 data phase while m0 holds a buffered response (fixed priority)
        cyc(); setm(0, 1, 32'h700, 0, 0);
        cyc(); setm(0, 1, 32'h704, 0, 0); setm(1, 1, 32'h900, 0, 0); s_rdata = 32'h77;
        sample(); chk("er_m0_stall", 32'(f_m0_hready), 0);
        cyc(); setm(1, 1, 32'h904, 0, 0); s_resp = 1; s_rdata = 32'hEE;
        sample(); chk("er_m1_resp", 32'(f_m1_hresp), 1); chk("er_m1_rdy", 32'(f_m1_hready), 1);
        chk("er_m0_resp", 32'(f_m0_hresp), 0); chk("er_m0_rdy", 32'(f_m0_hready), 0);
        cyc(); m_trans[1] = 0; s_resp = 0; s_rdata = 32'hF0;
        sample(); chk("er_m0_deliver", 32'(f_m0_hready), 1); chk("er_m0_data", f_m0_hrdata, 32'h77);
        chk("er_m1_data", f_m1_hrdata, 32'hF0);
        cyc(); idle_all();

        // reset with buffered response and in-flight data phase
        cyc(); setm(0, 1, 32'hA00, 0, 0);
        cyc(); setm(0, 1, 32'hA04, 0, 0); setm(1, 1, 32'hB00, 0, 0); s_rdata = 32'h99;
        cyc(); rstn = 0; idle_all(); s_rdata = 32'hABC;
        sample(); chk("mr_htrans", 32'(f_htrans), 0); chk("mr_m0_rdy", 32'(f_m0_hready), 1);
        chk("mr_m1_rdy", 32'(f_m1_hready), 1); chk("mr_m0_data", f_m0_hrdata, 32'hABC);
        chk("mr_htrans_rr", 32'(r_htrans), 0);
        cyc(); rstn = 1; setm(0, 1, 32'hC00, 0, 0);
        sample(); chk("mr_first_addr", f_haddr, 32'hC00); chk("mr_first_rdy", 32'(f_m0_hready), 1);
        cyc(); idle_all();

        // randomized traffic, checked by the per-cycle model compare
        for (int n = 0; n < 4000; n++) begin
            cyc();
            for (int i = 0; i < 2; i++) begin
                m_trans[i] = ($urandom_range(0, 99) < 60);
                m_addr[i]  = $urandom;
                m_prot[i]  = 1'($urandom);
                m_size[i]  = 2'($urandom);
                m_write[i] = 1'($urandom);
                m_wdata[i] = $urandom;
            end
            s_ready = ($urandom_range(0, 99) < 70);
            s_rdata = $urandom;
            s_resp  = ($urandom_range(0, 9) == 0);
            rstn    = ($urandom_range(0, 199) != 0);
        end
        cyc();
        rstn = 1;
        sample();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/busarb.md
Name: busarb

Overview:
- Two-master to one-slave arbiter for the core's AHB-lite-like bus.
- Master 0 is the instruction bus interface; master 1 is the data bus interface (haddr/hprot/hsize/hwrite/hwdata/htrans out; hrdata/hresp/hready in).
- Muxes address and data phases onto the single slave port and steers responses back.
- Buffers a completed response when its owner is stalled on a lost address phase, so no read data is lost.

Parameters:
ARB_MODE, 1, 0 = round-robin, 1 = fixed priority to master 1 (data)
RST_LAST, 0, master index treated as last-granted out of reset (round-robin only)

Ports:
clk  input  1  clock; all state on rising edge
rstn  input  1  asynchronous active-low reset
m0_haddr, m1_haddr  input  32  master address
m0_hprot, m1_hprot  input  1  data/instruction indicator
m0_hsize, m1_hsize  input  2  transfer size
m0_hwrite, m1_hwrite  input  1  write enable
m0_hwdata, m1_hwdata  input  32  write data, valid in the master's data phase
m0_htrans, m1_htrans  input  1  address-phase valid
m0_hrdata, m1_hrdata  output  32  read data to master
m0_hresp, m1_hresp  output  1  error to master
m0_hready, m1_hready  output  1  per-master ready
haddr, hprot, hsize, hwrite, hwdata, htrans  output  32/1/2/1/32/1  slave-side request
hrdata, hresp, hready  input  32/1/1  slave-side response

Behaviour:
- State:
  - hold_vld, hold_g: stalled address phase.
  - dp_vld, dp_own: data-phase owner.
  - last_g: round-robin pointer.
  - Per master i: rbuf_vld_i, rbuf_data_i[31:0], rbuf_err_i.
- Reset: all state cleared; last_g = RST_LAST.
  - Outputs at reset: htrans = 0.
  - mX_hready = 1 (no outstanding phase, no request).
  - mX_hrdata = slave hrdata; mX_hresp = slave hresp.
- Grant g (combinational):
  - If hold_vld, g = hold_g.
  - Else, if only one master requests, grant it.
  - If both request: ARB_MODE=1 grants master 1; ARB_MODE=0 grants ~last_g.
  - If none request, g = last_g and htrans = 0.
- Slave address mux:
  - haddr/hprot/hsize/hwrite = master g.
  - htrans = mg_htrans.
  - hwdata = master dp_own's hwdata (0 when !dp_vld).
- Edge update:
  - hold_vld <= htrans & ~hready; hold_g <= g.
  - On hready: dp_vld <= htrans, dp_own <= g. If htrans, last_g <= g.
  - With hready low, dp_vld and dp_own are unchanged.
- Per-master ready:
  - done_i = rbuf_vld_i | ~(dp_vld & dp_own==i) | hready.
  - acc_i = ~mi_htrans | (g==i & hready).
  - mi_hready = done_i & acc_i.
- Response buffer:
  - Capture when dp_vld & dp_own==i & hready & ~mi_hready: rbuf_vld_i <= 1 and capture hrdata/hresp.
  - Clear when mi_hready = 1.
  - Capture and clear never coincide.
  - mi_hrdata/mi_hresp = rbuf_vld_i ? buffered : slave.
- Latency: zero-cycle combinational address path; no added latency for an uncontested master.
- Boundaries:
  - A stalled address (hready low) is never re-arbitrated.
  - A master's buffered response is delivered in the same cycle its next address is accepted.
  - Simultaneous first requests follow ARB_MODE.
  - In ARB_MODE=0, neither master waits more than one foreign transfer.
  - Reset mid-transfer drops the in-flight phase and empties the buffers.

Decomposition:
- Package femto_bus_pkg:
  - master index constants M_IBUS=0, M_DBUS=1.
  - ARB_RR/ARB_FIXED constants.
  - A bus-request struct (addr, prot, size, write, trans).
- Sub-module busarb_rspbuf: one per master, holding rbuf_vld/data/err with capture and clear inputs; instantiated twice.

Test Plan:
- Single master: m0 reads 0x100 then 0x104 back-to-back, slave hready=1, m1 idle.
  -> haddr 0x100 then 0x104; m0_hready always 1; data returned one clock after each address.
- Collision, ARB_MODE=1: both assert htrans in the same cycle (m0 0x200, m1 0x8000_0000 write 0xDEADBEEF).
  -> m1 granted first, m0_hready=0 for one cycle; hwdata=0xDEADBEEF in m1's data phase; m0 accepted next cycle.
- Response buffering: m0 streams fetches while m1 requests, ARB_MODE=0.
  -> m0's completed read (0x13) is captured in rbuf, m0_hready=0 that cycle.
  -> When m0 is regranted, m0_hready=1 with m0_hrdata=0x13.
- Slave stall: hready held low 3 cycles during m1's address phase while m0 starts requesting.
  -> haddr/htrans stay on m1 for all 3 cycles; grant is unchanged until hready=1.
- Error path: slave hresp=1 on m1's data phase.
  -> m1_hresp=1 with m1_hready=1; m0_hresp=0.
- Reset: rstn low mid data phase with rbuf_vld_0=1.
  -> htrans=0, both mX_hready=1, rbuf cleared; first post-reset request is granted normally.
